// File: rtl/route_lookahead_stage_pkg.sv
// route_lookahead_stage_pkg: mesh types, look-ahead XY routing helpers and buffer payload
package route_lookahead_stage_pkg;
  localparam int MESH_X = 4;
  localparam int MESH_Y = 4;
  localparam int NUM_OUT = 5;
  typedef enum logic [2:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } t_cardinal;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    t_cardinal   next_tile_fifo_arb_id;
  } t_tile_trans;
  typedef struct packed {
    logic [NUM_OUT-1:0] port;
    t_tile_trans        trans;
  } t_route_entry;
  function automatic logic [7:0] neighbor_id(logic [7:0] id, t_cardinal dir);
    logic [3:0] x, y;
    x = dir == EAST ? id[7:4] + 4'd1 : dir == WEST ? id[7:4] - 4'd1 : id[7:4];
    y = dir == SOUTH ? id[3:0] + 4'd1 : dir == NORTH ? id[3:0] - 4'd1 : id[3:0];
    return {x, y};
  endfunction
  function automatic t_cardinal xy_next_dir(logic [7:0] cur_id, logic [7:0] dst_id);
    return dst_id[7:4] > cur_id[7:4] ? EAST :
           dst_id[7:4] < cur_id[7:4] ? WEST :
           dst_id[3:0] > cur_id[3:0] ? SOUTH :
           dst_id[3:0] < cur_id[3:0] ? NORTH : LOCAL;
  endfunction
  function automatic logic off_mesh(logic [7:0] id, t_cardinal dir);
    return (dir == WEST && id[7:4] == 4'd0) || (dir == EAST && id[7:4] == 4'(MESH_X - 1)) ||
           (dir == NORTH && id[3:0] == 4'd0) || (dir == SOUTH && id[3:0] == 4'(MESH_Y - 1));
  endfunction
endpackage

// File: rtl/route_lookahead_stage_if.sv
// route_lookahead_stage_if: valid/ready transaction link, N parallel valid/ready lanes sharing one req
interface route_lookahead_stage_if #(parameter int N = 1);
  import route_lookahead_stage_pkg::*;
  logic [N-1:0] valid;
  logic [N-1:0] ready;
  t_tile_trans  req;
  modport master(output valid, output req, input ready);
  modport slave(input valid, input req, output ready);
endinterface

// File: rtl/route_lookahead_stage_skid_buffer_2e.sv
// route_lookahead_stage_skid_buffer_2e: 2-entry elastic FIFO (main + skid), in_ready_o is a flop output
// ports: clk, rst (async active-low), in_valid_i/in_data_i/in_ready_o upstream, out_valid_o/out_data_o/out_ready_i downstream
module route_lookahead_stage_skid_buffer_2e #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic push, pop, main_ld_in, main_ld_skid, skid_ld;
  logic [DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  always_comb begin
    push = in_valid_i && !skid_v_q;
    pop = main_v_q && out_ready_i;
    main_ld_skid = pop && skid_v_q;
    main_ld_in = push && (!main_v_q || pop);
    skid_ld = push && main_v_q && !pop;
    main_v_d = main_ld_skid || main_ld_in || (main_v_q && !pop);
    skid_v_d = skid_ld || (skid_v_q && !pop);
    main_d = main_ld_skid ? skid_q : main_ld_in ? in_data_i : main_q;
    skid_d = skid_ld ? in_data_i : skid_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign in_ready_o = !skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o = main_q;
endmodule

// File: rtl/route_lookahead_stage.sv
// route_lookahead_stage: look-ahead router input stage, steers by stamped port and re-stamps the next hop
// ports: clk, rst (async active-low), local_tile_id_i {x,y}, in_if (slave, 1 lane),
//        out_if (master, NUM_OUT one-hot lanes, common req), err_illegal_route_o sticky off-mesh flag
module route_lookahead_stage
  import route_lookahead_stage_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     local_tile_id_i,
  route_lookahead_stage_if.slave         in_if,
  route_lookahead_stage_if.master        out_if,
  output logic                           err_illegal_route_o
);
  t_cardinal d;
  logic illegal, buf_in_valid, buf_in_ready, buf_out_valid, err_q, err_d;
  t_route_entry in_ent, out_ent;
  always_comb begin
    d = in_if.req.next_tile_fifo_arb_id;
    illegal = d > LOCAL || off_mesh(local_tile_id_i, d);
    in_ent.trans = in_if.req;
    in_ent.trans.next_tile_fifo_arb_id = d == LOCAL ? LOCAL :
      xy_next_dir(neighbor_id(local_tile_id_i, d), in_if.req.address[31:24]);
    in_ent.port = NUM_OUT'(1) << d;
    buf_in_valid = in_if.valid[0] && !illegal;
    err_d = err_q || (in_if.valid[0] && buf_in_ready && illegal);
  end
  route_lookahead_stage_skid_buffer_2e #(.DATA_WIDTH($bits(t_route_entry))) u_buf (
    .clk(clk),
    .rst(rst),
    .in_valid_i(buf_in_valid),
    .in_data_i(in_ent),
    .in_ready_o(buf_in_ready),
    .out_valid_o(buf_out_valid),
    .out_data_o(out_ent),
    .out_ready_i(|(out_ent.port & out_if.ready))
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign in_if.ready = buf_in_ready;
  assign out_if.valid = buf_out_valid ? out_ent.port : '0;
  assign out_if.req = out_ent.trans;
  assign err_illegal_route_o = err_q;
endmodule
